irq_ctrl: RTL and testbench



---
 rtl/irq_ctrl_pkg.sv | 46 ++++
 rtl/irq_timer.sv | 89 ++++++++
 rtl/irq_ctrl.sv | 125 ++++++++++++
 tb/tb_irq_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : irq_ctrl_pkg                                                    |
// | Purpose  : Shared constants and types for the machine-level interrupt      |
// |            controller: register offsets, mcause codes, mip bit positions,  |
// |            arbiter state encoding and the fixed-priority cause helper.     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package irq_ctrl_pkg;

   // Register byte offsets on the register bus
   localparam logic [15:0] OFF_MSIP        = 16'h0000;
   localparam logic [15:0] OFF_MTIMECMP_LO = 16'h4000;
   localparam logic [15:0] OFF_MTIMECMP_HI = 16'h4004;
   localparam logic [15:0] OFF_MTIME_LO    = 16'hBFF8;
   localparam logic [15:0] OFF_MTIME_HI    = 16'hBFFC;

   // mcause values for asynchronous interrupts
   localparam logic [31:0] INT_CAUSE_MEI = 32'h8000_000B;
   localparam logic [31:0] INT_CAUSE_MSI = 32'h8000_0003;
   localparam logic [31:0] INT_CAUSE_MTI = 32'h8000_0007;

   // mip bit indices
   localparam int MIP_MSIP = 3;
   localparam int MIP_MTIP = 7;
   localparam int MIP_MEIP = 11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } irq_state_e;

   // Fixed priority MEI > MSI > MTI. Only called when at least one enabled
   // source is pending, so "neither MEI nor MSI" means MTI.
   function automatic logic [31:0] prio_cause(input logic mei, input logic msi);
      if (mei) begin
         return INT_CAUSE_MEI;
      end else if (msi) begin
         return INT_CAUSE_MSI;
      end
      return INT_CAUSE_MTI;
   endfunction

endpackage
`default_nettype wire

// File: rtl/irq_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : irq_timer                                                       |
// | Purpose  : mtime/mtimecmp timer with prescaler, MTIP compare and the       |
// |            combinational read mux for its four register words.            |
// | Ports    : clk, rst_n       - clock, synchronous active-low reset           |
// |            bus_we_i         - register write strobe                        |
// |            bus_addr_i       - byte address                                 |
// |            bus_wdata_i      - write data                                   |
// |            rdata_o          - read data for this block's words, else 0     |
// |            mtip_o           - mtime >= mtimecmp                            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module irq_timer
   import irq_ctrl_pkg::*;
#(
   parameter int PRESCALE = 1,
   parameter int ADDR_W   = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              bus_we_i,
   input  logic [ADDR_W-1:0] bus_addr_i,
   input  logic [31:0]       bus_wdata_i,
   output logic [31:0]       rdata_o,
   output logic              mtip_o
);

   localparam int            PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] presc_q, presc_d;
   logic [63:0]   mtime_q, mtime_d;
   logic [63:0]   mtimecmp_q, mtimecmp_d;

   logic w_tick;
   logic w_sel_cmp_lo, w_sel_cmp_hi, w_sel_time_lo, w_sel_time_hi;

   assign w_sel_cmp_lo  = (bus_addr_i == ADDR_W'(OFF_MTIMECMP_LO));
   assign w_sel_cmp_hi  = (bus_addr_i == ADDR_W'(OFF_MTIMECMP_HI));
   assign w_sel_time_lo = (bus_addr_i == ADDR_W'(OFF_MTIME_LO));
   assign w_sel_time_hi = (bus_addr_i == ADDR_W'(OFF_MTIME_HI));

   assign w_tick = (presc_q == PRESC_LAST);

   always_comb begin
      presc_d    = w_tick ? '0 : presc_q + 1'b1;
      mtime_d    = w_tick ? mtime_q + 64'd1 : mtime_q;
      mtimecmp_d = mtimecmp_q;
      // A software write to an mtime half overrides the increment; the other
      // half keeps its old value so no carry crosses between halves.
      if (bus_we_i && w_sel_time_lo) begin
         mtime_d = {mtime_q[63:32], bus_wdata_i};
      end
      if (bus_we_i && w_sel_time_hi) begin
         mtime_d = {bus_wdata_i, mtime_q[31:0]};
      end
      if (bus_we_i && w_sel_cmp_lo) begin
         mtimecmp_d[31:0] = bus_wdata_i;
      end
      if (bus_we_i && w_sel_cmp_hi) begin
         mtimecmp_d[63:32] = bus_wdata_i;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         presc_q    <= '0;
         mtime_q    <= 64'd0;
         mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
      end else begin
         presc_q    <= presc_d;
         mtime_q    <= mtime_d;
         mtimecmp_q <= mtimecmp_d;
      end
   end

   assign mtip_o = (mtime_q >= mtimecmp_q);

   always_comb begin
      rdata_o = 32'd0;
      if (w_sel_cmp_lo)  rdata_o = mtimecmp_q[31:0];
      if (w_sel_cmp_hi)  rdata_o = mtimecmp_q[63:32];
      if (w_sel_time_lo) rdata_o = mtime_q[31:0];
      if (w_sel_time_hi) rdata_o = mtime_q[63:32];
   end

endmodule
`default_nettype wire

// File: rtl/irq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : irq_ctrl                                                        |
// | Purpose  : Machine-level interrupt source and scheduler. Holds msip,       |
// |            synchronises the external line, arbitrates pending enabled      |
// |            sources and issues one request at a time to clint.             |
// | Ports    : clk, rst_n             - clock, synchronous active-low reset     |
// |            bus_we/re/addr/wdata   - register bus write/read               |
// |            bus_rdata              - registered read data (1 cycle)         |
// |            irq_ext_i              - async external interrupt level         |
// |            csr_mie                - mie CSR                                |
// |            global_interrupt_enable- mstatus.MIE                            |
// |            hold_i                 - clint busy with a trap sequence        |
// |            irq_ack                - clint accepted the request             |
// |            irq_req / irq_cause    - request and its mcause value           |
// |            mip_o                  - live mip (bits 3, 7, 11)              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module irq_ctrl
   import irq_ctrl_pkg::*;
#(
   parameter int PRESCALE = 1,
   parameter int ADDR_W   = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              bus_we,
   input  logic              bus_re,
   input  logic [ADDR_W-1:0] bus_addr,
   input  logic [31:0]       bus_wdata,
   output logic [31:0]       bus_rdata,
   input  logic              irq_ext_i,
   input  logic [31:0]       csr_mie,
   input  logic              global_interrupt_enable,
   input  logic              hold_i,
   input  logic              irq_ack,
   output logic              irq_req,
   output logic [31:0]       irq_cause,
   output logic [31:0]       mip_o
);

   irq_state_e  state_q, state_d;
   logic [31:0] cause_q, cause_d;
   logic [31:0] rdata_q, rdata_d;
   logic        msip_q, msip_d;
   logic [1:0]  meip_sync_q;

   logic        w_sel_msip;
   logic        w_mtip;
   logic [31:0] w_timer_rdata;
   logic [31:0] w_pending;

   irq_timer #(
      .PRESCALE (PRESCALE),
      .ADDR_W   (ADDR_W)
   ) u_timer (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus_we_i    (bus_we),
      .bus_addr_i  (bus_addr),
      .bus_wdata_i (bus_wdata),
      .rdata_o     (w_timer_rdata),
      .mtip_o      (w_mtip)
   );

   assign w_sel_msip = (bus_addr == ADDR_W'(OFF_MSIP));
   assign msip_d     = (bus_we && w_sel_msip) ? bus_wdata[0] : msip_q;

   // Timer words and MSIP decode to disjoint addresses, so OR-ing is a mux.
   // Read data is sampled from the registers before this cycle's write lands.
   assign rdata_d = bus_re ? (w_timer_rdata | {31'd0, w_sel_msip & msip_q}) : rdata_q;

   always_comb begin
      mip_o           = 32'd0;
      mip_o[MIP_MEIP] = meip_sync_q[1];
      mip_o[MIP_MTIP] = w_mtip;
      mip_o[MIP_MSIP] = msip_q;
   end

   assign w_pending = mip_o & csr_mie;

   always_comb begin
      state_d = state_q;
      cause_d = cause_q;
      case (state_q)
         ST_IDLE: begin
            if (global_interrupt_enable && !hold_i && (w_pending != 32'd0)) begin
               cause_d = prio_cause(w_pending[MIP_MEIP], w_pending[MIP_MSIP]);
               state_d = ST_REQ;
            end
         end
         // Cause is frozen here until the ack, whatever the sources do.
         ST_REQ: begin
            if (irq_ack) state_d = ST_WAIT;
         end
         // Block re-issue until clint has finished the trap sequence.
         ST_WAIT: begin
            if (!hold_i) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cause_q     <= 32'd0;
         rdata_q     <= 32'd0;
         msip_q      <= 1'b0;
         meip_sync_q <= 2'b00;
      end else begin
         state_q     <= state_d;
         cause_q     <= cause_d;
         rdata_q     <= rdata_d;
         msip_q      <= msip_d;
         meip_sync_q <= {meip_sync_q[0], irq_ext_i};
      end
   end

   assign irq_req   = (state_q == ST_REQ);
   assign irq_cause = cause_q;
   assign bus_rdata = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_irq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_irq_ctrl                                                     |
// | Purpose  : Self-checking bench for irq_ctrl (PRESCALE=1 main instance and  |
// |            a PRESCALE=4 instance for the mtime write-priority case).      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_irq_ctrl;
   import irq_ctrl_pkg::*;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        bus_we, bus_re;
   logic [15:0] bus_addr;
   logic [31:0] bus_wdata, bus_rdata;
   logic        irq_ext_i, gie, hold_i, irq_ack, irq_req;
   logic [31:0] csr_mie, irq_cause, mip_o;

   logic        b4_we, b4_re;
   logic [15:0] b4_addr;
   logic [31:0] b4_wdata, b4_rdata, b4_cause, b4_mip;
   logic        b4_req;

   int          n_chk = 0;
   int          n_err = 0;
   logic [63:0] mt_ref;
   logic [31:0] exp_q[$];

   irq_ctrl #(.PRESCALE(1), .ADDR_W(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .bus_we(bus_we), .bus_re(bus_re),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
      .irq_ext_i(irq_ext_i), .csr_mie(csr_mie), .global_interrupt_enable(gie),
      .hold_i(hold_i), .irq_ack(irq_ack), .irq_req(irq_req),
      .irq_cause(irq_cause), .mip_o(mip_o)
   );

   irq_ctrl #(.PRESCALE(4), .ADDR_W(16)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .bus_we(b4_we), .bus_re(b4_re),
      .bus_addr(b4_addr), .bus_wdata(b4_wdata), .bus_rdata(b4_rdata),
      .irq_ext_i(1'b0), .csr_mie(32'd0), .global_interrupt_enable(1'b0),
      .hold_i(1'b0), .irq_ack(1'b0), .irq_req(b4_req),
      .irq_cause(b4_cause), .mip_o(b4_mip)
   );

   // Reference mtime for the main instance while no mtime writes occur
   always @(posedge clk) begin
      if (!rst_n) mt_ref <= 64'd0;
      else        mt_ref <= mt_ref + 64'd1;
   end

   typedef struct {
      logic        we;
      logic        re;
      logic [15:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
   } vec_t;

   vec_t vecs[16];

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) cyc();
      rst_n = 1'b1;
   endtask

   task automatic bus_wr(input logic [15:0] addr, input logic [31:0] data);
      bus_we = 1'b1; bus_addr = addr; bus_wdata = data;
      cyc();
      bus_we = 1'b0;
   endtask

   task automatic bus_rd(input string name, input logic [15:0] addr, input logic [31:0] exp);
      bus_re = 1'b1; bus_addr = addr;
      exp_q.push_back(exp);
      cyc();
      bus_re = 1'b0;
      chk(name, bus_rdata, exp_q.pop_front());
   endtask

   // Waits (bounded) for irq_req, then compares the cause with the scoreboard
   task automatic wait_req(input string name, input int budget);
      int n = 0;
      logic [31:0] e;
      while (!irq_req && n < budget) begin
         cyc();
         n++;
      end
      e = exp_q.pop_front();
      chk({name, "_req"}, {31'd0, irq_req}, 32'd1);
      if (irq_req) chk({name, "_cause"}, irq_cause, e);
   endtask

   task automatic ack_and_release();
      irq_ack = 1'b1; hold_i = 1'b1;
      cyc();
      irq_ack = 1'b0;
      cyc();
      hold_i = 1'b0;
      cyc();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int n;
      rst_n = 1'b0; bus_we = 1'b0; bus_re = 1'b0; bus_addr = 16'd0; bus_wdata = 32'd0;
      irq_ext_i = 1'b0; gie = 1'b0; hold_i = 1'b0; irq_ack = 1'b0; csr_mie = 32'd0;
      b4_we = 1'b0; b4_re = 1'b0; b4_addr = 16'd0; b4_wdata = 32'd0;

      vecs[0]  = '{1'b0, 1'b1, OFF_MSIP,        32'h0,         32'h0};
      vecs[1]  = '{1'b0, 1'b1, OFF_MTIMECMP_LO, 32'h0,         32'hFFFF_FFFF};
      vecs[2]  = '{1'b0, 1'b1, OFF_MTIMECMP_HI, 32'h0,         32'hFFFF_FFFF};
      vecs[3]  = '{1'b1, 1'b1, OFF_MSIP,        32'hFFFF_FFFF, 32'h0};
      vecs[4]  = '{1'b0, 1'b1, OFF_MSIP,        32'h0,         32'h1};
      vecs[5]  = '{1'b1, 1'b1, OFF_MSIP,        32'h0,         32'h1};
      vecs[6]  = '{1'b0, 1'b1, OFF_MSIP,        32'h0,         32'h0};
      vecs[7]  = '{1'b1, 1'b0, OFF_MTIMECMP_LO, 32'h1234_5678, 32'h0};
      vecs[8]  = '{1'b0, 1'b1, OFF_MTIMECMP_LO, 32'h0,         32'h1234_5678};
      vecs[9]  = '{1'b1, 1'b1, OFF_MTIMECMP_HI, 32'hCAFE_F00D, 32'hFFFF_FFFF};
      vecs[10] = '{1'b0, 1'b1, OFF_MTIMECMP_HI, 32'h0,         32'hCAFE_F00D};
      vecs[11] = '{1'b1, 1'b0, 16'h0004,        32'hDEAD_BEEF, 32'h0};
      vecs[12] = '{1'b0, 1'b1, 16'h0004,        32'h0,         32'h0};
      vecs[13] = '{1'b0, 1'b1, 16'h4008,        32'h0,         32'h0};
      vecs[14] = '{1'b0, 1'b1, OFF_MSIP,        32'h0,         32'h0};
      vecs[15] = '{1'b0, 1'b1, OFF_MTIME_HI,    32'h0,         32'h0};

      // Reset state
      do_reset();
      chk("rst_req",   {31'd0, irq_req}, 32'd0);
      chk("rst_cause", irq_cause, 32'd0);
      chk("rst_mip",   mip_o, 32'd0);
      chk("rst_rdata", bus_rdata, 32'd0);

      // Register map table
      for (int i = 0; i < 16; i++) begin
         bus_we = vecs[i].we; bus_re = vecs[i].re;
         bus_addr = vecs[i].addr; bus_wdata = vecs[i].wdata;
         if (vecs[i].re) exp_q.push_back(vecs[i].rdata);
         cyc();
         bus_we = 1'b0; bus_re = 1'b0;
         if (vecs[i].re) chk($sformatf("vec%0d", i), bus_rdata, exp_q.pop_front());
      end

      // 1. Timer fire
      do_reset();
      csr_mie = 32'h80; gie = 1'b1;
      bus_wr(OFF_MTIMECMP_HI, 32'd0);
      bus_wr(OFF_MTIMECMP_LO, 32'd20);
      bus_rd("mtime_count", OFF_MTIME_LO, mt_ref[31:0]);
      n = 0;
      while (!mip_o[MIP_MTIP] && n < 60) begin
         cyc();
         n++;
      end
      chk("mtip_rise_time", mt_ref[31:0], 32'd20);
      chk("mtip_mip", mip_o, 32'h80);
      chk("mtip_no_req_yet", {31'd0, irq_req}, 32'd0);
      cyc();
      exp_q.push_back(INT_CAUSE_MTI);
      wait_req("t1_first", 0);
      repeat (3) cyc();
      chk("t1_hold_req", {31'd0, irq_req}, 32'd1);
      chk("t1_hold_cause", irq_cause, INT_CAUSE_MTI);
      irq_ack = 1'b1; hold_i = 1'b1;
      cyc();
      irq_ack = 1'b0;
      chk("t1_req_drop", {31'd0, irq_req}, 32'd0);
      repeat (2) begin
         cyc();
         chk("t1_wait_no_req", {31'd0, irq_req}, 32'd0);
      end
      hold_i = 1'b0;
      cyc();
      chk("t1_idle_no_req", {31'd0, irq_req}, 32'd0);
      cyc();
      exp_q.push_back(INT_CAUSE_MTI);
      wait_req("t1_reissue", 0);
      gie = 1'b0; csr_mie = 32'd0;
      ack_and_release();

      // 2. Priority
      csr_mie = 32'h888;
      bus_wr(OFF_MSIP, 32'd1);
      irq_ext_i = 1'b1;
      repeat (3) cyc();
      chk("t2_mip_all", mip_o, 32'h888);
      gie = 1'b1;
      exp_q.push_back(INT_CAUSE_MEI);
      wait_req("t2_mei", 3);
      irq_ext_i = 1'b0;
      ack_and_release();
      exp_q.push_back(INT_CAUSE_MSI);
      wait_req("t2_msi", 3);
      gie = 1'b0;
      ack_and_release();

      // 3. Gating
      repeat (4) begin
         cyc();
         chk("t3_gie_off", {31'd0, irq_req}, 32'd0);
      end
      gie = 1'b1; hold_i = 1'b1;
      repeat (4) begin
         cyc();
         chk("t3_hold_on", {31'd0, irq_req}, 32'd0);
      end
      hold_i = 1'b0; gie = 1'b0;
      cyc();
      gie = 1'b1;
      cyc();
      exp_q.push_back(INT_CAUSE_MSI);
      wait_req("t3_gie_rise", 0);
      gie = 1'b0;
      ack_and_release();
      csr_mie = 32'h800; gie = 1'b1;
      repeat (4) begin
         cyc();
         chk("t3_mie_masked", {31'd0, irq_req}, 32'd0);
      end
      chk("t3_mip", mip_o, 32'h88);

      // 4. Cause stability
      csr_mie = 32'h880;
      bus_wr(OFF_MSIP, 32'd0);
      exp_q.push_back(INT_CAUSE_MTI);
      wait_req("t4_mti", 3);
      irq_ext_i = 1'b1;
      repeat (5) begin
         cyc();
         chk("t4_stable_req", {31'd0, irq_req}, 32'd1);
         chk("t4_stable_cause", irq_cause, INT_CAUSE_MTI);
      end
      gie = 1'b0; irq_ext_i = 1'b0;
      ack_and_release();
      csr_mie = 32'd0;
      repeat (2) cyc();

      // 5. mtime wrap after a two-half write
      for (int k = 1; k <= 2; k++) begin
         for (int h = 0; h < 2; h++) begin
            bus_wr(OFF_MTIME_HI, 32'hFFFF_FFFF);
            bus_wr(OFF_MTIME_LO, 32'hFFFF_FFFE);
            repeat (k) cyc();
            bus_rd($sformatf("t5_wrap_k%0d_h%0d", k, h),
                   (h == 0) ? OFF_MTIME_HI : OFF_MTIME_LO,
                   (k == 1) ? 32'hFFFF_FFFF : 32'h0);
         end
      end

      // 5b. Write wins over increment (PRESCALE=4 instance); a continuous
      // write covers every prescaler phase, each read returns the prior value.
      for (int i = 0; i < 6; i++) begin
         b4_we = 1'b1; b4_re = 1'b1; b4_addr = OFF_MTIME_LO; b4_wdata = 32'h100;
         if (i > 0) exp_q.push_back(32'h100);
         cyc();
         if (i > 0) chk($sformatf("t5_write_wins%0d", i), b4_rdata, exp_q.pop_front());
      end
      b4_we = 1'b0;
      exp_q.push_back(32'h100);
      cyc();
      b4_re = 1'b0;
      chk("t5_write_wins_last", b4_rdata, exp_q.pop_front());

      // 6. Reset during REQ
      csr_mie = 32'h008; gie = 1'b1;
      bus_wr(OFF_MSIP, 32'd1);
      exp_q.push_back(INT_CAUSE_MSI);
      wait_req("t6_pre", 3);
      rst_n = 1'b0;
      cyc();
      chk("t6_req",   {31'd0, irq_req}, 32'd0);
      chk("t6_cause", irq_cause, 32'd0);
      chk("t6_mip",   mip_o, 32'd0);
      rst_n = 1'b1;
      bus_rd("t6_mtime_lo", OFF_MTIME_LO, 32'd0);
      bus_rd("t6_cmp_hi", OFF_MTIMECMP_HI, 32'hFFFF_FFFF);
      bus_rd("t6_cmp_lo", OFF_MTIMECMP_LO, 32'hFFFF_FFFF);
      repeat (5) begin
         cyc();
         chk("t6_no_req", {31'd0, irq_req}, 32'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
`default_nettype wire
